handshake_rr_merge: RTL and testbench

HANDSHAKE_RR_MERGE -- requirements
Module: handshake_rr_merge

---
 rtl/handshake_rr_merge.sv | 138 +++++++++++++
 tb/tb_handshake_rr_merge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_merge.sv
// Three-input round-robin merge into a small FIFO output buffer.
// Each entry carries payload, source index and precomputed OR/AND reductions.
module handshake_rr_merge #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             in_0_valid,
  input  logic [WIDTH-1:0] in_0_data,
  output logic             in_0_ready,
  input  logic             in_1_valid,
  input  logic [WIDTH-1:0] in_1_data,
  output logic             in_1_ready,
  input  logic             in_2_valid,
  input  logic [WIDTH-1:0] in_2_data,
  output logic             in_2_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_orr,
  output logic             out_andr,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       src;
    logic             orr;
    logic             andr;
  } entry_t;

  entry_t        entry_q [DEPTH];
  entry_t        entry_d [DEPTH];
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    rr_q, rr_d;

  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [1:0]       grant_idx;
  logic             grant_any;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] grant_data;

  assign in_valid = {in_2_valid, in_1_valid, in_0_valid};

  function automatic logic [1:0] mod3_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Priority order is rr+1, rr+2, rr; first valid channel wins.
  always_comb begin
    grant_idx = rr_q;
    grant_any = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      logic [1:0] idx;
      idx = mod3_add(rr_q, 2'(i));
      if (!grant_any && in_valid[idx]) begin
        grant_idx = idx;
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    grant_data = in_0_data;
      2'd1:    grant_data = in_1_data;
      default: grant_data = in_2_data;
    endcase
  end

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign full = (count_q == CW'(DEPTH));
  assign push = grant_any && !full && ASYNCRESETN;
  assign pop  = (count_q != '0) && out_ready;

  assign in_ready   = push ? (3'b001 << grant_idx) : 3'b000;
  assign in_0_ready = in_ready[0];
  assign in_1_ready = in_ready[1];
  assign in_2_ready = in_ready[2];

  always_comb begin
    new_entry.data = grant_data;
    new_entry.src  = grant_idx;
    new_entry.orr  = |grant_data;
    new_entry.andr = &grant_data;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_d[i] = entry_q[i];
    if (push) entry_d[wr_ptr_q] = new_entry;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rr_d     = push ? grant_idx : rr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 2'd2;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // Head fields come straight from storage; entries clear on reset so outputs read zero.
  assign out_valid = (count_q != '0);
  assign out_data  = entry_q[rd_ptr_q].data;
  assign out_src   = entry_q[rd_ptr_q].src;
  assign out_orr   = entry_q[rd_ptr_q].orr;
  assign out_andr  = entry_q[rd_ptr_q].andr;
  assign count     = count_q;

endmodule

// File: tb/tb_handshake_rr_merge.sv
// Directed self-checking bench for handshake_rr_merge (WIDTH=4, DEPTH=2).
module tb_handshake_rr_merge;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       in_0_valid, in_1_valid, in_2_valid;
  logic [3:0] in_0_data, in_1_data, in_2_data;
  logic       in_0_ready, in_1_ready, in_2_ready;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_orr, out_andr;
  logic [1:0] count;
  logic [2:0] rdy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign rdy = {in_2_ready, in_1_ready, in_0_ready};

  handshake_rr_merge #(.WIDTH(4), .DEPTH(2)) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .in_0_valid (in_0_valid),
    .in_0_data  (in_0_data),
    .in_0_ready (in_0_ready),
    .in_1_valid (in_1_valid),
    .in_1_data  (in_1_data),
    .in_1_ready (in_1_ready),
    .in_2_valid (in_2_valid),
    .in_2_data  (in_2_data),
    .in_2_ready (in_2_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_orr    (out_orr),
    .out_andr   (out_andr),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_0_valid = 1'b0; in_1_valid = 1'b0; in_2_valid = 1'b0;
    in_0_data  = 4'h0; in_1_data  = 4'h0; in_2_data  = 4'h0;
    out_ready  = 1'b0;
  endtask

  // Release lands mid-cycle so it never coincides with a clock edge.
  task automatic do_reset();
    idle_inputs();
    ASYNCRESETN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 ASYNCRESETN = 1'b1;
    #1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    idle_inputs();
    ASYNCRESETN = 1'b0;
    in_0_valid = 1'b1; in_1_valid = 1'b1; in_2_valid = 1'b1;
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_src", 32'(out_src), 0);
    check("rst_orr", 32'(out_orr), 0);
    check("rst_andr", 32'(out_andr), 0);
    check("rst_ready", 32'(rdy), 0);
    do_reset();

    // Single word on channel 1
    in_1_valid = 1'b1; in_1_data = 4'hF; out_ready = 1'b1;
    #1 check("sw_ready", 32'(rdy), 'b010);
    step();
    in_1_valid = 1'b0;
    #1;
    check("sw_valid", 32'(out_valid), 1);
    check("sw_data", 32'(out_data), 'hF);
    check("sw_src", 32'(out_src), 1);
    check("sw_orr", 32'(out_orr), 1);
    check("sw_andr", 32'(out_andr), 1);
    check("sw_count", 32'(count), 1);
    step();
    check("sw_drain", 32'(count), 0);
    check("sw_empty", 32'(out_valid), 0);

    // Fairness with all channels valid
    do_reset();
    in_0_valid = 1'b1; in_1_valid = 1'b1; in_2_valid = 1'b1;
    in_0_data = 4'h1; in_1_data = 4'h2; in_2_data = 4'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_grant", 32'(rdy), 32'(1 << exp_seq[i]));
      if (i > 0) check("rr_src", 32'(out_src), 32'(exp_seq[i-1]));
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    step();
    check("rr_drain", 32'(count), 0);

    // Backpressure with channels 0 and 2
    do_reset();
    in_0_valid = 1'b1; in_0_data = 4'hA;
    in_2_valid = 1'b1; in_2_data = 4'h5;
    #1 check("bp_grant0", 32'(rdy), 'b001);
    step();
    #1 check("bp_grant2", 32'(rdy), 'b100);
    step();
    check("bp_count", 32'(count), 2);
    check("bp_full_rdy", 32'(rdy), 0);
    check("bp_head_src", 32'(out_src), 0);
    step();
    check("bp_hold_data", 32'(out_data), 'hA);
    check("bp_hold_rdy", 32'(rdy), 0);
    in_0_valid = 1'b0; in_2_valid = 1'b0; out_ready = 1'b1;
    #1 check("bp_out0_src", 32'(out_src), 0);
    step();
    check("bp_out1_src", 32'(out_src), 2);
    check("bp_out1_data", 32'(out_data), 'h5);
    check("bp_out1_count", 32'(count), 1);
    step();
    check("bp_drain", 32'(count), 0);
    check("bp_empty", 32'(out_valid), 0);

    // Full with pop: no push in the popping cycle
    do_reset();
    in_0_valid = 1'b1; in_0_data = 4'h1;
    step();
    step();
    check("fp_count2", 32'(count), 2);
    out_ready = 1'b1; in_0_data = 4'h7;
    #1 check("fp_full_rdy", 32'(rdy), 0);
    step();
    out_ready = 1'b0;
    #1;
    check("fp_count1", 32'(count), 1);
    check("fp_resume_rdy", 32'(rdy), 'b001);
    step();
    check("fp_count_back", 32'(count), 2);
    idle_inputs();
    out_ready = 1'b1;
    step();
    check("fp_tail_data", 32'(out_data), 'h7);
    step();
    check("fp_drain", 32'(count), 0);

    // Reductions for 0 and 6
    do_reset();
    in_0_valid = 1'b1; in_0_data = 4'h0;
    step();
    in_0_data = 4'h6;
    step();
    in_0_valid = 1'b0;
    #1;
    check("red0_orr", 32'(out_orr), 0);
    check("red0_andr", 32'(out_andr), 0);
    out_ready = 1'b1;
    step();
    check("red6_orr", 32'(out_orr), 1);
    check("red6_andr", 32'(out_andr), 0);
    check("red6_data", 32'(out_data), 'h6);

    // Asynchronous reset with two entries buffered
    do_reset();
    in_1_valid = 1'b1; in_1_data = 4'hC;
    step();
    step();
    in_1_valid = 1'b0;
    #1 check("ar_pre_count", 32'(count), 2);
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_valid", 32'(out_valid), 0);
    check("ar_data", 32'(out_data), 0);
    in_0_valid = 1'b1; in_1_valid = 1'b1; in_2_valid = 1'b1;
    #1 check("ar_rdy_low", 32'(rdy), 0);
    @(posedge CLK);
    #2 ASYNCRESETN = 1'b1;
    #1 check("ar_first_grant", 32'(rdy), 'b001);
    step();
    check("ar_src", 32'(out_src), 0);
    check("ar_post_count", 32'(count), 1);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
